// File: rtl/conv_enc_frame_ctrl.sv
// Frame controller for an external convolutional encoder: buffers a frame, clears the encoder, then streams bits (plus optional zero tail).
// Latency: first out_sym ENC_LAT+1 cycles after the first ENCODE cycle; done one cycle after the final symbol.
// Backpressure: in_valid stalls in LOAD hold state indefinitely; the symbol output has no backpressure.
//
// Ports: clk/reset (sync, active-high); start, in_valid/in_bit/in_ready (frame input);
//        enc_b/enc_reset/enc_c (encoder drive and return); out_valid/out_sym/out_last (symbols);
//        busy, done (status).
// Build option: define CONV_CTRL_TAIL_EN to append K-1 zero tail bits (terminates the trellis in state 0).
module conv_enc_frame_ctrl #(
   parameter int FRAME_LEN = 8,
   parameter int K         = 3,
   parameter int ENC_LAT   = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       in_valid,
   input  logic       in_bit,
   output logic       in_ready,
   output logic       enc_b,
   output logic       enc_reset,
   input  logic [1:0] enc_c,
   output logic       out_valid,
   output logic [1:0] out_sym,
   output logic       out_last,
   output logic       busy,
   output logic       done
);

   localparam int CW = $clog2(FRAME_LEN + K);
   localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CW-1:0] LAST_BIT   = CW'(FRAME_LEN - 1);
   localparam logic [CW-1:0] LAST_DRAIN = CW'(ENC_LAT);

`ifdef CONV_CTRL_TAIL_EN
   localparam logic [CW-1:0] LAST_TAIL = CW'(K - 2);
   typedef enum logic [2:0] {
      IDLE = 3'd0, LOAD = 3'd1, CLR = 3'd2, ENCODE = 3'd3, TAIL = 3'd4, DRAIN = 3'd5, DONE = 3'd6
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE = 3'd0, LOAD = 3'd1, CLR = 3'd2, ENCODE = 3'd3, DRAIN = 3'd5, DONE = 3'd6
   } state_t;
`endif

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [FRAME_LEN-1:0]   buf_q, buf_d;
   logic                   cnt_inc;
   logic                   sym_act, sym_last;
   logic                   act_aligned, last_aligned;
   logic                   out_valid_q, out_last_q;
   logic [1:0]             out_sym_q;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
      end
   end

   // Next-state logic. in_ready equals (state_q == LOAD), so capture needs only in_valid.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_inc = 1'b0;
      case (state_q)
         IDLE:   if (start) state_d = LOAD;
         LOAD: begin
            if (in_valid) begin
               buf_d[cnt_q[IW-1:0]] = in_bit;
               cnt_inc = 1'b1;
               if (cnt_q == LAST_BIT) state_d = CLR;
            end
         end
         CLR:    state_d = ENCODE;
         ENCODE: begin
            cnt_inc = 1'b1;
`ifdef CONV_CTRL_TAIL_EN
            if (cnt_q == LAST_BIT) state_d = TAIL;
`else
            if (cnt_q == LAST_BIT) state_d = DRAIN;
`endif
         end
`ifdef CONV_CTRL_TAIL_EN
         TAIL: begin
            cnt_inc = 1'b1;
            if (cnt_q == LAST_TAIL) state_d = DRAIN;
         end
`endif
         // Wait for the encoder pipeline and the output register to flush.
         DRAIN: begin
            cnt_inc = 1'b1;
            if (cnt_q == LAST_DRAIN) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // The counter restarts from zero on every state entry.
      if (state_d != state_q) cnt_d = '0;
      else if (cnt_inc)       cnt_d = cnt_q + CW'(1);
      else                    cnt_d = cnt_q;
   end

   // Output decode
   always_comb begin
      in_ready  = (state_q == LOAD);
      enc_reset = reset || (state_q == CLR);
      enc_b     = (state_q == ENCODE) ? buf_q[cnt_q[IW-1:0]] : 1'b0;
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
`ifdef CONV_CTRL_TAIL_EN
      sym_act   = (state_q == ENCODE) || (state_q == TAIL);
      sym_last  = (state_q == TAIL) && (cnt_q == LAST_TAIL);
`else
      sym_act   = (state_q == ENCODE);
      sym_last  = (state_q == ENCODE) && (cnt_q == LAST_BIT);
`endif
   end

   // Align symbol-valid/last flags with enc_c, which trails enc_b by ENC_LAT cycles.
   generate
      if (ENC_LAT == 1) begin : g_lat1
         logic act_dly_q, last_dly_q;
         always_ff @(posedge clk) begin
            if (reset) begin
               act_dly_q  <= 1'b0;
               last_dly_q <= 1'b0;
            end else begin
               act_dly_q  <= sym_act;
               last_dly_q <= sym_last;
            end
         end
         assign act_aligned  = act_dly_q;
         assign last_aligned = last_dly_q;
      end else begin : g_lat0
         assign act_aligned  = sym_act;
         assign last_aligned = sym_last;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_sym_q   <= 2'b00;
         out_last_q  <= 1'b0;
      end else begin
         out_valid_q <= act_aligned;
         out_sym_q   <= act_aligned ? enc_c : 2'b00;
         out_last_q  <= last_aligned;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sym   = out_sym_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// Bench for conv_enc_frame_ctrl: two instances share stimulus, one with a combinational
// K=3 encoder (ENC_LAT=0), one with a registered-output encoder (ENC_LAT=1).
// Stimulus changes 2 time units after the rising edge; the monitor samples on the falling edge.
module tb_conv_enc_frame_ctrl;

`ifdef CONV_CTRL_TAIL_EN
   localparam int NSYM = 10;
`else
   localparam int NSYM = 8;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b1, start = 1'b0, in_valid = 1'b0, in_bit = 1'b0;

   logic in_ready0, enc_b0, enc_reset0, out_valid0, out_last0, busy0, done0;
   logic [1:0] enc_c0, out_sym0;
   logic in_ready1, enc_b1, enc_reset1, out_valid1, out_last1, busy1, done1;
   logic [1:0] enc_c1, out_sym1;

   conv_enc_frame_ctrl #(.FRAME_LEN(8), .K(3), .ENC_LAT(0)) u0 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_bit(in_bit),
      .in_ready(in_ready0), .enc_b(enc_b0), .enc_reset(enc_reset0), .enc_c(enc_c0),
      .out_valid(out_valid0), .out_sym(out_sym0), .out_last(out_last0), .busy(busy0), .done(done0));

   conv_enc_frame_ctrl #(.FRAME_LEN(8), .K(3), .ENC_LAT(1)) u1 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_bit(in_bit),
      .in_ready(in_ready1), .enc_b(enc_b1), .enc_reset(enc_reset1), .enc_c(enc_c1),
      .out_valid(out_valid1), .out_sym(out_sym1), .out_last(out_last1), .busy(busy1), .done(done1));

   // Combinational-output encoder: c = {b^s1^s2, b^s2}
   logic s1_0 = 1'b0, s2_0 = 1'b0;
   assign enc_c0 = {enc_b0 ^ s1_0 ^ s2_0, enc_b0 ^ s2_0};
   always @(posedge clk) begin
      if (enc_reset0) begin s1_0 <= 1'b0; s2_0 <= 1'b0; end
      else begin s1_0 <= enc_b0; s2_0 <= s1_0; end
   end

   // Registered-output encoder (one cycle of latency)
   logic s1_1 = 1'b0, s2_1 = 1'b0;
   logic [1:0] c1_q = 2'b00;
   assign enc_c1 = c1_q;
   always @(posedge clk) begin
      if (enc_reset1) begin s1_1 <= 1'b0; s2_1 <= 1'b0; c1_q <= 2'b00; end
      else begin
         c1_q <= {enc_b1 ^ s1_1 ^ s2_1, enc_b1 ^ s2_1};
         s1_1 <= enc_b1; s2_1 <= s1_1;
      end
   end

   int checks = 0, failures = 0;
   logic [0:7] pat;
   logic [1:0] exp_sym [10];

   // Monitor
   int cyc = 0;
   logic [1:0] q0[$], q1[$];
   bit l0[$], l1[$];
   int done_n0, done_n1, first0, first1, clr0, clr1, lastc0, lastc1, donec0, donec1, busy_gap;
   bit track_busy = 1'b0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (out_valid0) begin
         q0.push_back(out_sym0); l0.push_back(out_last0);
         if (first0 < 0) first0 = cyc;
         if (out_last0) lastc0 = cyc;
      end
      if (out_valid1) begin
         q1.push_back(out_sym1); l1.push_back(out_last1);
         if (first1 < 0) first1 = cyc;
         if (out_last1) lastc1 = cyc;
      end
      if (done0) begin done_n0++; donec0 = cyc; end
      if (done1) begin done_n1++; donec1 = cyc; end
      if (enc_reset0 && !reset) clr0 = cyc;
      if (enc_reset1 && !reset) clr1 = cyc;
      if (track_busy && !busy0) busy_gap++;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_mon();
      q0.delete(); q1.delete(); l0.delete(); l1.delete();
      done_n0 = 0; done_n1 = 0; first0 = -1; first1 = -1;
      clr0 = -1; clr1 = -1; lastc0 = -1; lastc1 = -1; donec0 = -1; donec1 = -1;
      busy_gap = 0;
   endtask

   // Start a frame and feed pat, optionally pausing in_valid after bit stall_after.
   task automatic send_frame(input int stall_after, input int stall_len);
      start = 1'b1;
      step();
      start = 1'b0;
      track_busy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_bit   = pat[i];
         step();
         if (i == stall_after) begin
            in_valid = 1'b0;
            in_bit   = 1'b1;
            repeat (stall_len) step();
         end
      end
      in_valid = 1'b0;
      in_bit   = 1'b0;
   endtask

   // Wait (bounded) for done on the ENC_LAT=0 instance, then let the ENC_LAT=1 instance finish.
   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 60 && !ok; n++) begin
         if (done0) ok = 1'b1;
         else step();
      end
      track_busy = 1'b0;
      repeat (4) step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      checks++; if (in_ready0 !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready0); end
      checks++; if (enc_b0 !== 1'b0) begin failures++; $display("FAIL reset_enc_b got=%b want=0", enc_b0); end
      checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid0); end
      checks++; if (out_sym0 !== 2'b00) begin failures++; $display("FAIL reset_out_sym got=%b want=00", out_sym0); end
      checks++; if (out_last0 !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b want=0", out_last0); end
      checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy0); end
      checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done0); end
      checks++; if (enc_reset0 !== 1'b1) begin failures++; $display("FAIL reset_enc_reset got=%b want=1", enc_reset0); end
      reset = 1'b0;
      step();
      checks++; if (enc_reset0 !== 1'b0) begin failures++; $display("FAIL idle_enc_reset got=%b want=0", enc_reset0); end
      checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", busy0); end
   endtask

   task automatic test_frame();
      bit ok;
      clear_mon();
      send_frame(-1, 0);
      wait_done(ok);
      checks++; if (!ok) begin failures++; $display("FAIL frame_done_timeout got=none want=done"); end
      checks++; if (q0.size() != NSYM) begin failures++; $display("FAIL frame_count got=%0d want=%0d", q0.size(), NSYM); end
      for (int i = 0; i < NSYM && i < q0.size(); i++) begin
         checks++;
         if (q0[i] !== exp_sym[i]) begin failures++; $display("FAIL frame_sym%0d got=%b want=%b", i, q0[i], exp_sym[i]); end
         checks++;
         if (l0[i] !== (i == NSYM - 1)) begin failures++; $display("FAIL frame_last%0d got=%b want=%b", i, l0[i], (i == NSYM - 1)); end
      end
      checks++; if (donec0 != lastc0 + 1) begin failures++; $display("FAIL frame_done_timing got=%0d want=%0d", donec0, lastc0 + 1); end
      checks++; if (first0 - clr0 != 2) begin failures++; $display("FAIL frame_first_valid got=%0d want=2", first0 - clr0); end
      checks++; if (done_n0 != 1) begin failures++; $display("FAIL frame_done_count got=%0d want=1", done_n0); end
   endtask

   task automatic test_stall();
      bit ok;
      clear_mon();
      send_frame(3, 5);
      wait_done(ok);
      checks++; if (!ok) begin failures++; $display("FAIL stall_done_timeout got=none want=done"); end
      checks++; if (busy_gap != 0) begin failures++; $display("FAIL stall_busy_low got=%0d want=0", busy_gap); end
      checks++; if (q0.size() != NSYM) begin failures++; $display("FAIL stall_count got=%0d want=%0d", q0.size(), NSYM); end
      for (int i = 0; i < NSYM && i < q0.size(); i++) begin
         checks++;
         if (q0[i] !== exp_sym[i]) begin failures++; $display("FAIL stall_sym%0d got=%b want=%b", i, q0[i], exp_sym[i]); end
      end
   endtask

   task automatic test_start_ignored();
      bit ok;
      bit seen = 1'b0;
      clear_mon();
      send_frame(-1, 0);
      for (int n = 0; n < 20 && !seen; n++) begin
         if (out_valid0) seen = 1'b1;
         else step();
      end
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done(ok);
      repeat (20) step();
      checks++; if (!ok) begin failures++; $display("FAIL startign_done_timeout got=none want=done"); end
      checks++; if (done_n0 != 1) begin failures++; $display("FAIL startign_done_count got=%0d want=1", done_n0); end
      checks++; if (q0.size() != NSYM) begin failures++; $display("FAIL startign_count got=%0d want=%0d", q0.size(), NSYM); end
      checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL startign_busy got=%b want=0", busy0); end
      checks++; if (in_ready0 !== 1'b0) begin failures++; $display("FAIL startign_in_ready got=%b want=0", in_ready0); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int nv = 0;
      clear_mon();
      send_frame(-1, 0);
      for (int n = 0; n < 30 && nv < 4; n++) begin
         step();
         if (out_valid0) nv++;
      end
      checks++; if (nv != 4) begin failures++; $display("FAIL rstmid_reach4 got=%0d want=4", nv); end
      reset = 1'b1;
      step();
      checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid0); end
      checks++; if (out_sym0 !== 2'b00) begin failures++; $display("FAIL rstmid_out_sym got=%b want=00", out_sym0); end
      checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy0); end
      checks++; if (enc_b0 !== 1'b0) begin failures++; $display("FAIL rstmid_enc_b got=%b want=0", enc_b0); end
      checks++; if (enc_reset0 !== 1'b1) begin failures++; $display("FAIL rstmid_enc_reset got=%b want=1", enc_reset0); end
      reset = 1'b0;
      repeat (20) step();
      checks++; if (q0.size() != 4) begin failures++; $display("FAIL rstmid_no_more_syms got=%0d want=4", q0.size()); end
      checks++; if (done_n0 != 0 || lastc0 != -1) begin failures++; $display("FAIL rstmid_no_done_last got=%0d/%0d want=0/-1", done_n0, lastc0); end
      clear_mon();
      send_frame(-1, 0);
      wait_done(ok);
      checks++; if (!ok) begin failures++; $display("FAIL rstmid_new_done_timeout got=none want=done"); end
      checks++; if (q0.size() != NSYM) begin failures++; $display("FAIL rstmid_new_count got=%0d want=%0d", q0.size(), NSYM); end
      for (int i = 0; i < NSYM && i < q0.size(); i++) begin
         checks++;
         if (q0[i] !== exp_sym[i]) begin failures++; $display("FAIL rstmid_new_sym%0d got=%b want=%b", i, q0[i], exp_sym[i]); end
      end
   endtask

   task automatic test_lat1();
      bit ok;
      clear_mon();
      send_frame(-1, 0);
      wait_done(ok);
      checks++; if (done_n1 != 1) begin failures++; $display("FAIL lat1_done_count got=%0d want=1", done_n1); end
      checks++; if (q1.size() != NSYM) begin failures++; $display("FAIL lat1_count got=%0d want=%0d", q1.size(), NSYM); end
      for (int i = 0; i < NSYM && i < q1.size(); i++) begin
         checks++;
         if (q1[i] !== exp_sym[i]) begin failures++; $display("FAIL lat1_sym%0d got=%b want=%b", i, q1[i], exp_sym[i]); end
      end
      checks++; if (l1.size() > 0 && l1[l1.size() - 1] !== 1'b1) begin failures++; $display("FAIL lat1_last got=0 want=1"); end
      checks++; if (first1 - clr1 != 3) begin failures++; $display("FAIL lat1_first_valid got=%0d want=3", first1 - clr1); end
      checks++; if (donec1 != lastc1 + 1) begin failures++; $display("FAIL lat1_done_timing got=%0d want=%0d", donec1, lastc1 + 1); end
   endtask

   initial begin
      pat = 8'b01011001;
      exp_sym = '{2'b00, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b11};
      clear_mon();
      test_reset();
      test_frame();
      test_stall();
      test_start_ignored();
      test_reset_mid();
      test_lat1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
